regfile_write_arbiter: RTL and testbench

//  Shares the single write port (cload/csel/cin) of the 8x8 register file between NREQ requesters.

---
 rtl/regfile_write_arbiter_pkg.sv | 29 ++
 rtl/regfile_write_arbiter_if.sv | 40 ++++
 rtl/regfile_write_arbiter_rr_priority_pick.sv | 46 ++++
 rtl/regfile_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_pkg
//  Description : Shared widths, lock-state encoding and index helper for the
//                register-file write arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int AW       = 3;   // register address width (csel)
    localparam int DW       = 8;   // register data width (cin)
    localparam int NREQ_MAX = 8;   // largest supported requester count
    localparam int GID_W    = 3;   // width of a requester index

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } lock_state_t;

    // Requester index k+1, wrapping to 0 at n.
    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] k, input int n);
        if (int'(k) + 1 >= n) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Requester handshake bundle plus the register-file write port
//                and status outputs of the write arbiter.
//                master : requester side / register-file side (testbench)
//                slave  : the arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) ();

    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 cload;
    logic [AW-1:0]        csel;
    logic [DW-1:0]        cin;
    logic [GID_W-1:0]     grant_id;
    logic [(1<<AW)-1:0]   pend;
    logic                 busy;

    modport master (
        output stall, req_valid, req_lock, req_addr, req_data,
        input  req_ready, cload, csel, cin, grant_id, pend, busy
    );

    modport slave (
        input  stall, req_valid, req_lock, req_addr, req_data,
        output req_ready, cload, csel, cin, grant_id, pend, busy
    );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational rotating-priority picker. Searches i_req
//                starting at i_ptr and wrapping mod N; returns a one-hot
//                grant, its index and whether anything was picked.
//  Ports       : i_req   [N]     request vector
//                i_ptr   [GID_W] highest-priority position
//                o_grant [N]     one-hot grant (zero if no request)
//                o_idx   [GID_W] index of the granted bit
//                o_any           1 when o_grant is non-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [GID_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant,
    output logic      [GID_W-1:0] o_idx,
    output logic                  o_any
);

    always_comb begin
        int w_k;
        w_k     = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_k = (int'(i_ptr) + i) % N;
            // Inner loop keeps every vector index a constant.
            for (int j = 0; j < N; j++) begin
                if (!o_any && (j == w_k) && i_req[j]) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = GID_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register-file write port among NREQ requesters
//                with round-robin arbitration, an optional burst lock with
//                idle timeout, and a one-cycle registered write stage.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - slave side of regfile_write_arbiter_if
//                       (stall, req_*, req_ready, cload/csel/cin,
//                        grant_id, pend, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LOCK_TO = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int         c_PEND_W    = 1 << AW;
    localparam logic [3:0] c_LOCK_LAST = 4'(LOCK_TO - 1);

    lock_state_t           r_state;
    logic [GID_W-1:0]      r_owner;
    logic [GID_W-1:0]      r_rr_ptr;
    logic [3:0]            r_lock_cnt;

    logic                  r_cload;
    logic [AW-1:0]         r_csel;
    logic [DW-1:0]         r_cin;
    logic [GID_W-1:0]      r_gid;
    logic [c_PEND_W-1:0]   r_pend;

    logic [NREQ-1:0]       w_owner_mask;
    logic                  w_owner_valid;
    logic [NREQ-1:0]       w_req_eff;
    logic [NREQ-1:0]       w_grant;
    logic [GID_W-1:0]      w_gidx;
    logic                  w_xfer;
    logic                  w_lock_sel;
    logic [AW-1:0]         w_addr;
    logic [DW-1:0]         w_data;
    logic [c_PEND_W-1:0]   w_pend_next;

    assign w_owner_mask  = NREQ'(1) << r_owner;
    assign w_owner_valid = |(bus.req_valid & w_owner_mask);

    // While a lock is held only the owner competes; stall masks everyone.
    always_comb begin
        w_req_eff = '0;
        if (!bus.stall) begin
            w_req_eff = (r_state == OWNED) ? (bus.req_valid & w_owner_mask) : bus.req_valid;
        end
    end

    rr_priority_pick #(
        .N       (NREQ)
    ) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_xfer)
    );

    assign bus.req_ready = w_grant;
    assign w_lock_sel    = |(w_grant & bus.req_lock);

    // One-hot AND-OR mux of the winner's address and data.
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_addr = w_addr | bus.req_addr[k*AW +: AW];
                w_data = w_data | bus.req_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_pend_next = '0;
        if (w_xfer) begin
            w_pend_next[w_addr] = 1'b1;
        end
    end

    // Write stage: csel/cin/grant_id hold their last values when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cload <= 1'b0;
            r_csel  <= '0;
            r_cin   <= '0;
            r_gid   <= '0;
            r_pend  <= '0;
        end else begin
            r_cload <= w_xfer;
            r_pend  <= w_pend_next;
            if (w_xfer) begin
                r_csel <= w_addr;
                r_cin  <= w_data;
                r_gid  <= w_gidx;
            end
        end
    end

    // Lock FSM with round-robin pointer and idle-timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (w_lock_sel) begin
                            r_state    <= OWNED;
                            r_owner    <= w_gidx;
                            r_lock_cnt <= '0;
                        end else begin
                            r_rr_ptr <= wrap_inc(w_gidx, NREQ);
                        end
                    end
                end
                OWNED: begin
                    if (w_xfer) begin
                        r_lock_cnt <= '0;
                        if (!w_lock_sel) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= wrap_inc(r_owner, NREQ);
                        end
                    end else if (!bus.stall && !w_owner_valid) begin
                        // Only unstalled idle cycles count toward the timeout.
                        if (r_lock_cnt == c_LOCK_LAST) begin
                            r_state    <= IDLE;
                            r_rr_ptr   <= wrap_inc(r_owner, NREQ);
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cload    = r_cload;
    assign bus.csel     = r_csel;
    assign bus.cin      = r_cin;
    assign bus.grant_id = r_gid;
    assign bus.pend     = r_pend;
    assign bus.busy     = (r_state == OWNED);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed bench for regfile_write_arbiter with a behavioural
//                reference model compared every cycle plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int LOCK_TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_write_arbiter #(
        .NREQ    (NREQ),
        .LOCK_TO (LOCK_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         rr;
        int         owner;   // -1 when nobody holds a lock
        int         idle;
        logic       cload;
        logic [2:0] csel;
        logic [7:0] cin;
        int         gid;
        logic [7:0] pend;
    } model_t;

    model_t m;

    function automatic model_t reset_model();
        model_t r;
        r.rr = 0; r.owner = -1; r.idle = 0;
        r.cload = 1'b0; r.csel = '0; r.cin = '0; r.gid = 0; r.pend = '0;
        return r;
    endfunction

    function automatic logic [3:0] exp_ready(input model_t s);
        if (bus.stall) return 4'b0;
        if (s.owner >= 0) return bus.req_valid[s.owner] ? (4'b1 << s.owner) : 4'b0;
        for (int i = 0; i < NREQ; i++) begin
            int kk;
            kk = (s.rr + i) % NREQ;
            if (bus.req_valid[kk]) return 4'b1 << kk;
        end
        return 4'b0;
    endfunction

    function automatic model_t next_model(input model_t s);
        model_t     n;
        logic [3:0] rdy;
        int         k;
        n   = s;
        rdy = exp_ready(s);
        k   = -1;
        for (int i = 0; i < NREQ; i++) if (rdy[i]) k = i;
        if (k >= 0) begin
            n.cload = 1'b1;
            n.csel  = bus.req_addr[k*3 +: 3];
            n.cin   = bus.req_data[k*8 +: 8];
            n.gid   = k;
            n.pend  = 8'(1) << n.csel;
            n.idle  = 0;
            if (s.owner < 0) begin
                if (bus.req_lock[k]) n.owner = k;
                else                 n.rr = (k + 1) % NREQ;
            end else if (!bus.req_lock[k]) begin
                n.owner = -1;
                n.rr    = (k + 1) % NREQ;
            end
        end else begin
            n.cload = 1'b0;
            n.pend  = '0;
            if (s.owner >= 0 && !bus.stall && !bus.req_valid[s.owner]) begin
                n.idle = s.idle + 1;
                if (n.idle == LOCK_TO) begin
                    n.rr    = (s.owner + 1) % NREQ;
                    n.owner = -1;
                    n.idle  = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= reset_model();
        else      m <= next_model(m);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("ready",    32'(bus.req_ready), 32'(exp_ready(m)));
        chk("cload",    32'(bus.cload),     32'(m.cload));
        chk("csel",     32'(bus.csel),      32'(m.csel));
        chk("cin",      32'(bus.cin),       32'(m.cin));
        chk("grant_id", 32'(bus.grant_id),  32'(m.gid));
        chk("pend",     32'(bus.pend),      32'(m.pend));
        chk("busy",     32'(bus.busy),      32'(m.owner >= 0));
    end

    // ---------------- write log / register-file image ----------------
    int         gid_log[$];
    int         busy_cnt = 0;
    logic [7:0] tb_rf [8];

    always @(negedge clk) begin
        if (bus.cload) begin
            gid_log.push_back(int'(bus.grant_id));
            tb_rf[bus.csel] <= bus.cin;
        end
        if (bus.busy) busy_cnt <= busy_cnt + 1;
    end

    // seq holds expected grant ids, element i in nibble i (LSB first).
    task automatic chk_log(input string nm, input int s, input int n, input logic [31:0] seq);
        for (int i = 0; i < n; i++) begin
            chk(nm, (s + i < gid_log.size()) ? 32'(gid_log[s+i]) : 32'hFFFF_FFFF, 32'(seq[4*i +: 4]));
        end
        chk({nm, "_len"}, 32'(gid_log.size() - s), 32'(n));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic s);
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.stall     = s;
    endtask

    task automatic set_ad(input int k, input logic [2:0] a, input logic [7:0] d);
        bus.req_addr[k*3 +: 3] = a;
        bus.req_data[k*8 +: 8] = d;
    endtask

    int lg0;
    int b0;

    initial begin
        drive(4'b0, 4'b0, 1'b0);
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int k = 0; k < NREQ; k++) set_ad(k, 3'(k), 8'hA0 + 8'(k));

        // Reset state
        repeat (2) step();
        rst = 1'b1;
        chk("rst_cload", 32'(bus.cload), 32'd0);
        chk("rst_pend",  32'(bus.pend),  32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);

        // 1: async reset while cload=1; rr_ptr back to 0 afterwards
        drive(4'b0001, 4'b0, 1'b0);
        step();
        drive(4'b0, 4'b0, 1'b0);
        chk("pre_rst_cload", 32'(bus.cload), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_cload", 32'(bus.cload), 32'd0);
        chk("async_pend",  32'(bus.pend),  32'd0);
        chk("async_busy",  32'(bus.busy),  32'd0);
        @(negedge clk);
        #1 rst = 1'b1;

        // 2: round robin, all four requesting for 8 cycles
        drive(4'b1111, 4'b0, 1'b0);
        #1;
        chk("rr_ptr_after_rst", 32'(bus.req_ready), 32'h1);
        lg0 = gid_log.size();
        repeat (8) step();
        drive(4'b0, 4'b0, 1'b0);
        repeat (2) step();
        chk_log("rr_seq", lg0, 8, 32'h3210_3210);

        // 3: lock burst by requester 1 with 0 and 2 competing
        drive(4'b0001, 4'b0, 1'b0);
        step();
        drive(4'b0, 4'b0, 1'b0);
        step();
        lg0 = gid_log.size();
        b0  = busy_cnt;
        drive(4'b0111, 4'b0010, 1'b0);
        repeat (3) step();
        drive(4'b0111, 4'b0000, 1'b0);
        repeat (3) step();
        drive(4'b0, 4'b0, 1'b0);
        repeat (2) step();
        chk_log("lock_seq", lg0, 6, 32'h02_1111);
        chk("lock_busy_cycles", 32'(busy_cnt - b0), 32'd3);

        // 4a: lock timeout, no stall
        lg0 = gid_log.size();
        b0  = busy_cnt;
        drive(4'b1000, 4'b1000, 1'b0);
        step();
        drive(4'b0001, 4'b0, 1'b0);
        repeat (4) step();
        chk("to_busy_low",  32'(bus.busy),      32'd0);
        chk("to_ready_req0", 32'(bus.req_ready), 32'h1);
        step();
        drive(4'b0, 4'b0, 1'b0);
        repeat (2) step();
        chk_log("to_seq", lg0, 2, 32'h03);
        chk("to_busy_cycles", 32'(busy_cnt - b0), 32'd4);

        // 4b: lock timeout stretched by a 2-cycle stall
        lg0 = gid_log.size();
        b0  = busy_cnt;
        drive(4'b1000, 4'b1000, 1'b0);
        step();
        drive(4'b0001, 4'b0, 1'b1);
        repeat (2) step();
        drive(4'b0001, 4'b0, 1'b0);
        repeat (4) step();
        chk("tos_ready_req0", 32'(bus.req_ready), 32'h1);
        step();
        drive(4'b0, 4'b0, 1'b0);
        repeat (2) step();
        chk_log("tos_seq", lg0, 2, 32'h03);
        chk("tos_busy_cycles", 32'(busy_cnt - b0), 32'd6);

        // 5: stall with requester 2 waiting behind a prior write
        drive(4'b0010, 4'b0, 1'b0);
        step();
        drive(4'b0100, 4'b0, 1'b1);
        #1;
        chk("stall_ready0",  32'(bus.req_ready), 32'h0);
        chk("stall_cload",   32'(bus.cload),     32'd1);
        chk("stall_gid",     32'(bus.grant_id),  32'd1);
        step();
        chk("stall_cload2",  32'(bus.cload),     32'd0);
        chk("stall_ready1",  32'(bus.req_ready), 32'h0);
        step();
        drive(4'b0100, 4'b0, 1'b0);
        #1;
        chk("unstall_ready", 32'(bus.req_ready), 32'h4);
        step();
        chk("unstall_cload", 32'(bus.cload),     32'd1);
        chk("unstall_gid",   32'(bus.grant_id),  32'd2);
        drive(4'b0, 4'b0, 1'b0);
        repeat (2) step();

        // 6: two requesters writing register 5, rr_ptr=0
        drive(4'b1000, 4'b0, 1'b0);
        step();
        drive(4'b0, 4'b0, 1'b0);
        step();
        set_ad(0, 3'd5, 8'h11);
        set_ad(1, 3'd5, 8'h22);
        drive(4'b0011, 4'b0, 1'b0);
        step();
        drive(4'b0010, 4'b0, 1'b0);
        chk("same_pend0", 32'(bus.pend),     32'h20);
        chk("same_gid0",  32'(bus.grant_id), 32'd0);
        chk("same_cin0",  32'(bus.cin),      32'h11);
        step();
        drive(4'b0, 4'b0, 1'b0);
        chk("same_pend1", 32'(bus.pend),     32'h20);
        chk("same_gid1",  32'(bus.grant_id), 32'd1);
        chk("same_cin1",  32'(bus.cin),      32'h22);
        step();
        chk("idle_cload", 32'(bus.cload),    32'd0);
        chk("idle_pend",  32'(bus.pend),     32'h0);
        chk("hold_csel",  32'(bus.csel),     32'd5);
        chk("hold_cin",   32'(bus.cin),      32'h22);
        step();
        chk("rf5_final",  32'(tb_rf[5]),     32'h22);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
